// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at launch and committed after a fixed per-op latency.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    // Full 2*WIDTH product; the low 2*WIDTH bits of the extended product are exact.
    function automatic logic [2*WIDTH-1:0] mult_result(input logic [WIDTH-1:0] a,
                                                       input logic [WIDTH-1:0] b,
                                                       input logic             is_signed);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}; signed division works on magnitudes and fixes signs after.
    function automatic logic [2*WIDTH-1:0] div_result(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b,
                                                      input logic             is_signed);
        logic [WIDTH-1:0] abs_a;
        logic [WIDTH-1:0] abs_b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        if (b == ZERO_W) begin
            return {a, ALL_ONES};
        end else if (is_signed && (a == MIN_NEG) && (b == ALL_ONES)) begin
            return {ZERO_W, MIN_NEG};
        end else if (is_signed) begin
            abs_a = a[WIDTH-1] ? -a : a;
            abs_b = b[WIDTH-1] ? -b : b;
            q     = abs_a / abs_b;
            r     = abs_a % abs_b;
            if (a[WIDTH-1] != b[WIDTH-1]) begin
                q = -q;
            end else begin
                q = q;
            end
            if (a[WIDTH-1]) begin
                r = -r;
            end else begin
                r = r;
            end
            return {r, q};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    logic [0:0]         state_r;
    logic               busy_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   pend_hi_r;
    logic [WIDTH-1:0]   pend_lo_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] result_s;
    logic [CNT_W-1:0]   cnt_load_s;

    // Result and latency selection for the operation being launched.
    always_comb begin
        result_s   = {(2*WIDTH){1'b0}};
        cnt_load_s = {CNT_W{1'b0}};
        case (md_op)
            2'b00:   result_s = mult_result(rs_data, rt_data, 1'b1);
            2'b01:   result_s = mult_result(rs_data, rt_data, 1'b0);
            2'b10:   result_s = div_result(rs_data, rt_data, 1'b1);
            2'b11:   result_s = div_result(rs_data, rt_data, 1'b0);
            default: result_s = {(2*WIDTH){1'b0}};
        endcase
        if (md_op[1]) begin
            cnt_load_s = CNT_W'(DIV_CYCLES - 1);
        end else begin
            cnt_load_s = CNT_W'(MULT_CYCLES - 1);
        end
    end

    // IDLE/RUN sequencing, pending result capture, commit and MTHI/MTLO writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            cnt_r     <= {CNT_W{1'b0}};
            pend_hi_r <= ZERO_W;
            pend_lo_r <= ZERO_W;
            hi_r      <= ZERO_W;
            lo_r      <= ZERO_W;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        pend_hi_r <= result_s[2*WIDTH-1:WIDTH];
                        pend_lo_r <= result_s[WIDTH-1:0];
                        cnt_r     <= cnt_load_s;
                        busy_r    <= 1'b1;
                        state_r   <= RUN;
                    end else begin
                        if (mthi) begin
                            hi_r <= rs_data;
                        end
                        if (mtlo) begin
                            lo_r <= rs_data;
                        end
                    end
                end
                RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        hi_r    <= pend_hi_r;
                        lo_r    <= pend_lo_r;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
